adder_result_accum: RTL and testbench
=====================================

Name: adder_result_accum

Overview:
- Downstream consumer of the N-bit ripple adder.
- Each cycle it may take one adder result, {carry, sum}, as an unsigned (N+1)-bit value under a valid/ready handshake.
- It sums a programmable number of results into a wide accumulator. When the frame completes, it presents the total on a held valid/ready output port.
- Typical use: averaging or checksum collection of adder outputs before they leave the datapath.

Parameters:
- N, 2, width of the adder sum input (same N as the adder stage).
- CNT_W, 4, width of the frame-length control and the internal sample counter.
- ACC_W, N+1+CNT_W, accumulator/output width. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: drop the current frame or pending result.
- in_valid  input  1  {carry, sum} valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- sum  input  N  adder sum bits.
- carry  input  1  adder carry-out, MSB of the sample value.
- num_samples  input  CNT_W  frame length. Value 0 means 2^CNT_W.
- out_valid  output  1  accumulated result available.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  accumulated frame total.

Behaviour:
- The single clock is clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n low.
- Reset values:
  - state = ACC
  - accumulator = 0
  - sample counter = 0
  - latched length = 0
  - out_valid = 0
  - acc_out = 0
  - in_ready = 1 (decoded from state)
- Sample value:
  - Sample = {carry, sum}, (N+1) bits, zero-extended to ACC_W.
  - The maximum frame total, (2^(N+1)-1)*2^CNT_W, fits in ACC_W. Overflow cannot occur; no overflow flag.
- State ACC:
  - in_ready = 1, out_valid = 0.
  - A sample is accepted on a cycle with in_valid & in_ready.
  - Accept with counter == 0: latch num_samples as the frame length, with 0 mapped to 2^CNT_W.
    - Changes to num_samples later in the frame are ignored until the next frame starts.
  - Each accept: accumulator += sample, counter += 1.
  - Accept that makes counter equal the latched length:
    - acc_out <= accumulator + sample.
    - Go to OUT.
    - out_valid = 1 on the next cycle, i.e. latency of one cycle after the last accepted sample.
- State OUT:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1, and acc_out is held stable until out_valid & out_ready.
  - On that handshake, on the next edge: state = ACC, accumulator = 0, counter = 0, out_valid = 0, in_ready = 1.
  - There is no same-cycle bypass from out_ready to in_ready, so there is one bubble cycle between frames.
- clear:
  - Highest priority below reset.
  - In either state, the next edge sets state = ACC and zeroes accumulator and counter. out_valid = 0; acc_out keeps its last value.
  - A sample handshaked in the same cycle as clear is discarded.
- Simultaneous events:
  - clear together with the last sample: the frame is discarded, no result.
  - clear together with out_ready in OUT: same as clear.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from any input to any output.
- Mid-frame rst_n assertion loses the partial frame. The first post-reset accepted sample starts a new frame.

Test Plan:
1. Reset, N=2, CNT_W=4: rst_n low -> out_valid=0, acc_out=0, in_ready=1. Release and idle 3 cycles -> outputs unchanged.
2. num_samples=3, samples 3'b111, 3'b101, 3'b010 on consecutive cycles -> one cycle after the third accept: out_valid=1, acc_out=14, in_ready=0.
3. Backpressure: after scenario 2, hold out_ready=0 for 5 cycles while driving in_valid=1 with value 7 -> acc_out stays 14, no sample counted. Raise out_ready -> next cycle out_valid=0, in_ready=1. A new 1-sample frame of value 4 -> acc_out=4.
4. num_samples=0: 16 samples of value 7 -> out_valid after the 16th accept, acc_out=112. No result after the 15th.
5. clear mid-frame:
   - num_samples=4, two samples of 5, then clear with in_valid=1 and value 6 -> no out_valid.
   - Next frame num_samples=2, samples 1, 1 -> acc_out=2.
   - Then clear during OUT -> out_valid drops next cycle, in_ready=1.
6. Length latch and async reset:
   - Start a frame with num_samples=3, change it to 1 after the first accept -> the result appears only after 3 samples.
   - Assert rst_n low asynchronously mid-frame -> outputs return to reset values immediately. The next frame counts from zero.

Source files
------------

// File: rtl/adder_result_accum_if.sv
// Handshake bundle between an adder stage and adder_result_accum.
//
// Producer side (master): clear, in_valid, sum, carry, num_samples, out_ready.
// Consumer side (slave, the accumulator): in_ready, out_valid, acc_out.
//
// Parameters
//   N      width of the adder sum bits
//   CNT_W  width of the frame-length control
//   ACC_W  accumulator / result width, always N+1+CNT_W
interface adder_result_accum_if #(
    parameter int N     = 2,
    parameter int CNT_W = 4
);
    localparam int ACC_W = N + 1 + CNT_W;

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     sum;
    logic             carry;
    logic [CNT_W-1:0] num_samples;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;

    modport master (
        output clear,
        output in_valid,
        output sum,
        output carry,
        output num_samples,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  sum,
        input  carry,
        input  num_samples,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out
    );
endinterface

// File: rtl/adder_result_accum.sv
// Frame accumulator for ripple-adder results.
//
// Takes one {carry, sum} sample per accepted handshake, sums a programmable
// number of samples (num_samples, 0 meaning 2^CNT_W) and presents the frame
// total on a held valid/ready output. One bubble cycle separates frames.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    adder_result_accum_if.slave
//            clear        synchronous abort of frame / pending result
//            in_valid     sample valid          in_ready   sample accepted
//            sum, carry   sample value {carry, sum}
//            num_samples  frame length, latched on the first sample of a frame
//            out_valid    result available      out_ready  result taken
//            acc_out      frame total, held while out_valid
//
// State | meaning
// ------+----------------------------------------------------------
// ACC   | collecting samples, in_ready = 1
// OUT   | frame total presented, waiting for out_ready, in_ready = 0
module adder_result_accum #(
    parameter int N     = 2,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_result_accum_if.slave   bus
);
    localparam int ACC_W = N + 1 + CNT_W;
    // Counter and latched length need one extra bit to hold 2^CNT_W.
    localparam int LEN_W = CNT_W + 1;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_out_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] ns_len;
    logic [LEN_W-1:0] frame_len;
    logic [LEN_W-1:0] cnt_next;
    logic             accept;
    logic             last;

    always_comb begin
        sample_ext = {{(ACC_W-N-1){1'b0}}, bus.carry, bus.sum};
        acc_next   = acc_q + sample_ext;
        ns_len     = (bus.num_samples == '0) ? (LEN_W'(1) << CNT_W)
                                             : {1'b0, bus.num_samples};
        // The first sample of a frame uses the live length; later samples use
        // the latched copy so mid-frame changes of num_samples are ignored.
        frame_len  = (cnt_q == '0) ? ns_len : len_q;
        cnt_next   = cnt_q + LEN_W'(1);
        accept     = (state == ACC) && bus.in_valid;
        last       = accept && (cnt_next == frame_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            acc_q       <= '0;
            acc_out_q   <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            // acc_out deliberately keeps its last value.
            state       <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            len_q <= ns_len;
                        end
                        acc_q <= acc_next;
                        cnt_q <= cnt_next;
                        if (last) begin
                            acc_out_q   <= acc_next;
                            out_valid_q <= 1'b1;
                            state       <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state       <= ACC;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

    // Outputs come straight from registers: no input-to-output path.
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;

endmodule

// File: tb/tb_adder_result_accum.sv
module tb_adder_result_accum;
    localparam int N     = 2;
    localparam int CNT_W = 4;
    localparam int ACC_W = N + 1 + CNT_W;

    logic clk;
    logic rst_n;

    adder_result_accum_if #(.N(N), .CNT_W(CNT_W)) bus ();

    adder_result_accum #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frames as plain integer sums over accepted samples.
    logic [ACC_W-1:0] exp_q[$];
    int m_cnt;
    int m_len;
    int m_total;
    bit m_pending;

    initial begin
        m_cnt = 0; m_len = 0; m_total = 0; m_pending = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0; m_total = 0; m_pending = 0;
                exp_q.delete();
            end else if (bus.clear) begin
                if (m_pending) void'(exp_q.pop_back());
                m_pending = 0; m_cnt = 0; m_total = 0;
            end else if (m_pending) begin
                if (bus.out_ready) m_pending = 0;
            end else if (bus.in_valid) begin
                if (m_cnt == 0)
                    m_len = (bus.num_samples == 0) ? (1 << CNT_W) : int'(bus.num_samples);
                m_total = m_total + int'({bus.carry, bus.sum});
                m_cnt++;
                if (m_cnt == m_len) begin
                    exp_q.push_back(ACC_W'(m_total));
                    m_pending = 1;
                    m_cnt = 0;
                    m_total = 0;
                end
            end
        end
    end

    // Monitor: compares handshake flags and every delivered result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid_flag", bus.out_valid, m_pending);
                check("in_ready_flag", bus.in_ready, !m_pending);
                if (bus.out_valid && bus.out_ready && !bus.clear) begin
                    if (exp_q.size() == 0) begin
                        check("result_queue_nonempty", exp_q.size(), 1);
                    end else begin
                        check("result_total", bus.acc_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [N:0] v);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        {bus.carry, bus.sum} = v;
        n = 0;
        do begin
            ok = bus.in_ready;
            step();
            n++;
        end while (!ok && n < 100);
        if (!ok) check("send_accepted", ok, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        check("wait_out_valid", bus.out_valid, 1);
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] exp);
        wait_valid();
        check("result_value", bus.acc_out, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("after_take_out_valid", bus.out_valid, 0);
        check("after_take_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int len;
        logic [CNT_W-1:0] ns;
        rst_n            = 1'b0;
        bus.clear        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.sum          = '0;
        bus.carry        = 1'b0;
        bus.num_samples  = '0;
        bus.out_ready    = 1'b0;

        // 1. reset
        #3;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_acc_out", bus.acc_out, 0);
        check("reset_in_ready", bus.in_ready, 1);
        step();
        rst_n = 1'b1;
        idle(3);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_acc_out", bus.acc_out, 0);
        check("idle_in_ready", bus.in_ready, 1);

        // 2. three-sample frame
        bus.num_samples = 4'd3;
        send(3'b111);
        send(3'b101);
        send(3'b010);
        check("s2_out_valid", bus.out_valid, 1);
        check("s2_acc_out", bus.acc_out, 14);
        check("s2_in_ready", bus.in_ready, 0);

        // 3. backpressure, then bubble and a 1-sample frame
        bus.in_valid = 1'b1;
        {bus.carry, bus.sum} = 3'd7;
        repeat (5) begin
            step();
            check("s3_hold_acc_out", bus.acc_out, 14);
            check("s3_hold_out_valid", bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("s3_release_out_valid", bus.out_valid, 0);
        check("s3_release_in_ready", bus.in_ready, 1);
        bus.num_samples = 4'd1;
        send(3'd4);
        bus.in_valid = 1'b0;
        expect_result(4);

        // 4. num_samples = 0 means 16
        bus.num_samples = 4'd0;
        repeat (15) send(3'd7);
        idle(2);
        check("s4_no_result_at_15", bus.out_valid, 0);
        send(3'd7);
        bus.in_valid = 1'b0;
        check("s4_valid_after_16", bus.out_valid, 1);
        expect_result(112);

        // 5. clear mid-frame, then clear during OUT
        bus.num_samples = 4'd4;
        send(3'd5);
        send(3'd5);
        {bus.carry, bus.sum} = 3'd6;
        bus.clear = 1'b1;
        step();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        idle(4);
        check("s5_no_result_after_clear", bus.out_valid, 0);
        bus.num_samples = 4'd2;
        send(3'd1);
        send(3'd1);
        bus.in_valid = 1'b0;
        wait_valid();
        check("s5_acc_out", bus.acc_out, 2);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("s5_clear_out_valid", bus.out_valid, 0);
        check("s5_clear_in_ready", bus.in_ready, 1);
        check("s5_clear_keeps_acc_out", bus.acc_out, 2);

        // 6. length latch
        bus.num_samples = 4'd3;
        send(3'd1);
        bus.num_samples = 4'd1;
        send(3'd2);
        idle(2);
        check("s6_no_early_result", bus.out_valid, 0);
        send(3'd3);
        bus.in_valid = 1'b0;
        expect_result(6);

        // 6b. asynchronous reset mid-frame
        bus.num_samples = 4'd4;
        send(3'd1);
        send(3'd2);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_in_ready", bus.in_ready, 1);
        check("async_rst_acc_out", bus.acc_out, 0);
        step();
        rst_n = 1'b1;
        bus.num_samples = 4'd2;
        send(3'd3);
        send(3'd3);
        bus.in_valid = 1'b0;
        expect_result(6);

        // Randomised frames with gaps, ready delays and mid-frame length changes.
        for (int f = 0; f < 12; f++) begin
            ns = CNT_W'($urandom_range(0, 5));
            bus.num_samples = ns;
            len = (ns == 0) ? (1 << CNT_W) : int'(ns);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send((N+1)'($urandom_range(0, 7)));
                bus.num_samples = CNT_W'($urandom);
            end
            bus.in_valid = 1'b0;
            wait_valid();
            repeat ($urandom_range(0, 3)) step();
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
